// File: rtl/popcount_pkg.sv
// Shared state encoding and slice popcount helper for the serial popcount unit.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Slices of up to 4 bits are zero-extended into this helper.
  function automatic logic [2:0] popcnt4(input logic [3:0] s);
    popcnt4 = {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
  endfunction

endpackage

// File: rtl/shreg_load_shift.sv
// Operand shift register: parallel load, zero-filled right shift by STEP, zero detect.
module shreg_load_shift #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [STEP-1:0]  slice_o,
  output logic             is_zero_o
);

  logic [WIDTH-1:0] shreg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          shreg_q <= '0;
    else if (load_i)  shreg_q <= din_i;
    else if (shift_i) shreg_q <= shreg_q >> STEP;
  end

  assign slice_o   = shreg_q[STEP-1:0];
  assign is_zero_o = (shreg_q == '0);

endmodule

// File: rtl/popcount_serial.sv
// Bit-serial ones counter and parity generator; scans STEP bits per clock and
// finishes as soon as the remaining operand bits are all zero.
module popcount_serial
  import popcount_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             par
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d, count_q, count_d;
  logic             par_q, par_d, mode_q, mode_d;
  logic             ld, sh, is_zero;
  logic [STEP-1:0]  slice;
  logic [3:0]       slice4;

  shreg_load_shift #(.WIDTH(WIDTH), .STEP(STEP)) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ld),
    .shift_i   (sh),
    .din_i     (data_in),
    .slice_o   (slice),
    .is_zero_o (is_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      par_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      par_q   <= par_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    par_d   = par_q;
    mode_d  = mode_q;
    ld      = 1'b0;
    sh      = 1'b0;
    slice4  = '0;
    slice4[STEP-1:0] = slice;
    case (state_q)
      IDLE: if (init) state_d = LOAD;
      LOAD: begin
        ld      = 1'b1;
        acc_d   = '0;
        mode_d  = mode;
        state_d = SCAN;
      end
      SCAN: begin
        // Results only move on completion so the previous answer stays visible.
        if (is_zero) begin
          state_d = DONE;
          count_d = acc_q;
          par_d   = acc_q[0] ^ mode_q;
        end else begin
          sh    = 1'b1;
          acc_d = acc_q + CNT_W'(popcnt4(slice4));
        end
      end
      DONE: if (!init) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == LOAD) || (state_q == SCAN);
  assign done  = (state_q == DONE);
  assign count = count_q;
  assign par   = par_q;

endmodule

// File: tb/tb_popcount_serial.sv
// Scoreboard bench for popcount_serial: an 8-bit/1-step and a 16-bit/4-step instance.
module tb_popcount_serial;

  typedef struct {
    int cnt;
    int par;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_a = 1'b0, mode_a = 1'b0, init_b = 1'b0, mode_b = 1'b0;
  logic [7:0]  data_a = '0;
  logic [15:0] data_b = '0;
  logic        busy_a, done_a, par_a, busy_b, done_b, par_b;
  logic [3:0]  count_a;
  logic [4:0]  count_b;

  int   checks = 0, errors = 0;
  int   prev_a = 0, prev_b = 0;
  exp_t qa[$], qb[$];
  logic done_a_d = 1'b0, done_b_d = 1'b0;

  always #5 clk = ~clk;

  popcount_serial #(.WIDTH(8), .STEP(1)) dut_a (
    .clk(clk), .rst(rst), .init(init_a), .mode(mode_a), .data_in(data_a),
    .busy(busy_a), .done(done_a), .count(count_a), .par(par_a)
  );

  popcount_serial #(.WIDTH(16), .STEP(4)) dut_b (
    .clk(clk), .rst(rst), .init(init_b), .mode(mode_b), .data_in(data_b),
    .busy(busy_b), .done(done_b), .count(count_b), .par(par_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Results are compared when done rises.
  always @(negedge clk) begin
    exp_t e;
    if (done_a && !done_a_d) begin
      if (qa.size() == 0) chk("qa_empty", 1, 0);
      else begin
        e = qa.pop_front();
        chk("cnt_a", int'(count_a), e.cnt);
        chk("par_a", int'(par_a), e.par);
      end
    end
    if (done_b && !done_b_d) begin
      if (qb.size() == 0) chk("qb_empty", 1, 0);
      else begin
        e = qb.pop_front();
        chk("cnt_b", int'(count_b), e.cnt);
        chk("par_b", int'(par_b), e.par);
      end
    end
    done_a_d = done_a;
    done_b_d = done_b;
  end

  task automatic set_in(input bit b, input logic i, input logic [15:0] d, input logic m);
    if (b) begin init_b = i; data_b = d; mode_b = m; end
    else   begin init_a = i; data_a = d[7:0]; mode_a = m; end
  endtask

  task automatic run_op(input bit b, input logic [15:0] d, input bit m,
                        input bit hold, input bit tog);
    int   w, st, k, lat, pc, ei;
    logic [15:0] dd;
    exp_t e;
    logic dn, bs;
    w  = b ? 16 : 8;
    st = b ? 4 : 1;
    dd = b ? d : {8'h00, d[7:0]};
    k  = -1;
    for (int i = 0; i < w; i++) if (dd[i]) k = i;
    lat = (k < 0) ? 3 : 3 + ((k + 1) + st - 1) / st;
    pc  = $countones(dd);
    e.cnt = pc;
    e.par = (pc & 1) ^ int'(m);
    if (b) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    set_in(b, 1'b1, dd, m);
    for (ei = 1; ei <= 60; ei++) begin
      @(posedge clk); #1;
      if (ei == 1 && !hold) begin
        if (b) init_b = 1'b0; else init_a = 1'b0;
      end
      if (ei == 2) chk("hold_old", b ? int'(count_b) : int'(count_a), b ? prev_b : prev_a);
      if (tog && ei >= 2) set_in(b, b ? init_b : init_a, ~dd, ~(b ? mode_b : mode_a));
      dn = b ? done_b : done_a;
      if (dn) break;
    end
    chk("latency", ei, lat);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      dn = b ? done_b : done_a;
      bs = b ? busy_b : busy_a;
      chk("done_held", int'(dn), 1);
      chk("no_restart", int'(bs), 0);
      if (b) init_b = 1'b0; else init_a = 1'b0;
      @(posedge clk); #1;
      dn = b ? done_b : done_a;
      chk("back_idle", int'(dn), 0);
    end else begin
      @(posedge clk); #1;
      dn = b ? done_b : done_a;
      chk("done_pulse", int'(dn), 0);
    end
    if (b) prev_b = pc; else prev_a = pc;
  endtask

  initial begin
    #2;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_cnt", int'(count_a), 0);
    chk("rst_par", int'(par_a), 0);
    chk("rst_done_b", int'(done_b), 0);
    @(negedge clk); rst = 1'b0;

    run_op(0, 16'h0000, 0, 0, 0);
    run_op(0, 16'h00FF, 0, 0, 0);
    run_op(0, 16'h0080, 0, 0, 0);
    run_op(0, 16'h0001, 0, 0, 0);
    run_op(0, 16'h0007, 1, 0, 0);
    run_op(0, 16'h0003, 1, 0, 0);
    run_op(0, 16'h00A5, 0, 0, 1);
    run_op(0, 16'h003C, 1, 1, 0);

    // Abort mid-scan: no result, no pending scoreboard entry.
    @(negedge clk);
    set_in(0, 1'b1, 16'h00FF, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; init_a = 1'b0;
    #1;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_cnt", int'(count_a), 0);
    chk("abort_par", int'(par_a), 0);
    @(negedge clk); rst = 1'b0;
    prev_a = 0;
    prev_b = 0;
    run_op(0, 16'h0055, 0, 0, 0);

    run_op(1, 16'hF00F, 0, 0, 0);
    run_op(1, 16'h0001, 0, 0, 0);
    run_op(1, 16'hFFFF, 1, 0, 0);
    run_op(1, 16'h0000, 0, 1, 0);

    repeat (2) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
